// File: rtl/nq_decode_stage_if.sv
// Fetch / writeback / ID-EX bundle seen by the nanoQuarter decode stage.
// slave = the decode stage, master = its surroundings (fetch, WB, execute).
interface nq_decode_stage_if #(
  parameter int DW  = 16,
  parameter int PCW = 32
);
  logic           if_valid;
  logic           if_ready;
  logic [15:0]    instr_in;
  logic [PCW-1:0] pc_in;
  logic           flush;

  logic           wb_en;
  logic [2:0]     wb_addr;
  logic [DW-1:0]  wb_data;

  logic           ex_valid;
  logic [DW-1:0]  reg1data_out;
  logic [DW-1:0]  reg2data_out;
  logic [7:0]     jtarget_out;
  logic [5:0]     memaddr_out;
  logic [4:0]     boffset_out;
  logic [2:0]     funct_out;
  logic [2:0]     ALUfunct_out;
  logic [1:0]     op_out;
  logic [1:0]     shamt_out;
  logic           bne_out;
  logic           jr_out;
  logic           memread_out;
  logic           memwrite_out;
  logic [2:0]     rd_out;
  logic           regwrite_out;
  logic [PCW-1:0] pc_out;

  modport slave (
    input  if_valid, instr_in, pc_in, flush, wb_en, wb_addr, wb_data,
    output if_ready, ex_valid, reg1data_out, reg2data_out, jtarget_out,
           memaddr_out, boffset_out, funct_out, ALUfunct_out, op_out,
           shamt_out, bne_out, jr_out, memread_out, memwrite_out, rd_out,
           regwrite_out, pc_out
  );

  modport master (
    output if_valid, instr_in, pc_in, flush, wb_en, wb_addr, wb_data,
    input  if_ready, ex_valid, reg1data_out, reg2data_out, jtarget_out,
           memaddr_out, boffset_out, funct_out, ALUfunct_out, op_out,
           shamt_out, bne_out, jr_out, memread_out, memwrite_out, rd_out,
           regwrite_out, pc_out
  );
endinterface

// File: rtl/nq_decode_stage.sv
// nanoQuarter decode / register-read stage: field decode, 8x16 regfile, ID/EX register.
// Optional load-use interlock enabled by defining NQ_LOADUSE_STALL_EN.
module nq_decode_stage #(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int PCW   = 32
) (
  input  logic clk,
  input  logic rst,
  nq_decode_stage_if.slave bus
);

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_M = 2'b01;
  localparam logic [1:0] OP_J = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef struct packed {
    logic [DW-1:0]  r1;
    logic [DW-1:0]  r2;
    logic [7:0]     jt;
    logic [5:0]     ma;
    logic [4:0]     bo;
    logic [2:0]     fn;
    logic [2:0]     alu;
    logic [1:0]     op;
    logic [1:0]     sh;
    logic           bne;
    logic           jr;
    logic           mr;
    logic           mw;
    logic [2:0]     rd;
    logic           rw;
    logic [PCW-1:0] pc;
  } idex_t;

  logic [NREGS-1:0][DW-1:0] rf_q;
  idex_t                    idex_q, idex_d;
  logic                     ex_valid_q;

  logic [1:0]    op;
  logic [2:0]    fn;
  logic [2:0]    ra1, ra2;
  logic [DW-1:0] rdata1, rdata2;
  logic          stall, rdy, xfer;

  assign op  = bus.instr_in[15:14];
  assign fn  = bus.instr_in[2:0];
  // Port 1 is rs, or the base register (rt) for memory ops; port 2 is rt,
  // which memory ops keep in [13:11].
  assign ra1 = bus.instr_in[13:11];
  assign ra2 = (op == OP_M) ? bus.instr_in[13:11] : bus.instr_in[10:8];

  // Register file; r0 is never written and reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '0;
    end else if (bus.wb_en && bus.wb_addr != 3'd0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Write-through so a same-cycle writeback is visible to the decoding instruction.
  always_comb begin
    rdata1 = rf_q[ra1];
    rdata2 = rf_q[ra2];
    if (ra1 == 3'd0)                            rdata1 = '0;
    else if (bus.wb_en && bus.wb_addr == ra1)   rdata1 = bus.wb_data;
    if (ra2 == 3'd0)                            rdata2 = '0;
    else if (bus.wb_en && bus.wb_addr == ra2)   rdata2 = bus.wb_data;
  end

  always_comb begin
    idex_d    = '0;
    idex_d.r1 = rdata1;
    idex_d.r2 = rdata2;
    idex_d.jt = bus.instr_in[10:3];
    idex_d.ma = bus.instr_in[10:5];
    idex_d.bo = bus.instr_in[7:3];
    idex_d.fn = fn;
    idex_d.op = op;
    idex_d.sh = bus.instr_in[4:3];
    idex_d.pc = bus.pc_in;
    case (op)
      OP_R: begin
        idex_d.alu = fn;
        if (fn != 3'b111) begin
          idex_d.rw = 1'b1;
          idex_d.rd = bus.instr_in[7:5];
        end
      end
      OP_M: begin
        idex_d.alu = ALU_ADD;
        case (fn)
          3'b000, 3'b010: begin
            idex_d.mr = 1'b1;
            idex_d.rw = 1'b1;
            idex_d.rd = bus.instr_in[13:11];
          end
          3'b001, 3'b011: idex_d.mw = 1'b1;
          default: ;
        endcase
      end
      OP_J: begin
        idex_d.alu = ALU_ADD;
        idex_d.jr  = (fn == 3'b001);
      end
      default: begin
        idex_d.alu = ALU_SUB;
        idex_d.bne = (fn == 3'b000);
      end
    endcase
  end

`ifdef NQ_LOADUSE_STALL_EN
  // Hold the consumer of a load for one cycle; the bubble then clears ex_valid.
  logic uses_rt;
  assign uses_rt = (op == OP_R) || (op == 2'b11);
  assign stall = ex_valid_q && idex_q.mr && (idex_q.rd != 3'd0) && bus.if_valid &&
                 ((ra1 == idex_q.rd) || (uses_rt && bus.instr_in[10:8] == idex_q.rd));
`else
  assign stall = 1'b0;
`endif

  assign rdy  = rst && !bus.flush && !stall;
  assign xfer = bus.if_valid && rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      idex_q     <= '0;
    end else begin
      ex_valid_q <= xfer;
      if (xfer) idex_q <= idex_d;
    end
  end

  assign bus.if_ready     = rdy;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.reg1data_out = idex_q.r1;
  assign bus.reg2data_out = idex_q.r2;
  assign bus.jtarget_out  = idex_q.jt;
  assign bus.memaddr_out  = idex_q.ma;
  assign bus.boffset_out  = idex_q.bo;
  assign bus.funct_out    = idex_q.fn;
  assign bus.ALUfunct_out = idex_q.alu;
  assign bus.op_out       = idex_q.op;
  assign bus.shamt_out    = idex_q.sh;
  assign bus.bne_out      = idex_q.bne;
  assign bus.jr_out       = idex_q.jr;
  assign bus.memread_out  = ex_valid_q & idex_q.mr;
  assign bus.memwrite_out = idex_q.mw;
  assign bus.rd_out       = idex_q.rd;
  assign bus.regwrite_out = ex_valid_q & idex_q.rw;
  assign bus.pc_out       = idex_q.pc;

endmodule

// File: tb/tb_nq_decode_stage.sv
// Self-checking bench for nq_decode_stage: directed plan items plus random traffic
// against an instruction-level reference model.
module tb_nq_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [7:0]  jt;
    logic [5:0]  ma;
    logic [4:0]  bo;
    logic [2:0]  fn;
    logic [2:0]  alu;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic        bne;
    logic        jr;
    logic        mr;
    logic        mw;
    logic [2:0]  rd;
    logic        rw;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nq_decode_stage_if #(.DW(16), .PCW(32)) bus();
  nq_decode_stage #(.NREGS(8), .DW(16), .PCW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [15:0] mrf [8];
  exp_t cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rdreg(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return mrf[a];
  endfunction

  // Instruction semantics: what execute should see for this word.
  function automatic exp_t model_decode(input logic [15:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [2:0] a, b, f;
    a = ins[13:11]; b = ins[10:8]; f = ins[2:0];
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.op = ins[15:14]; e.fn = f;
    e.sh = ins[4:3]; e.jt = ins[10:3]; e.ma = ins[10:5]; e.bo = ins[7:3];
    case (ins[15:14])
      2'd0: begin
        e.r1 = rdreg(a); e.r2 = rdreg(b); e.alu = f;
        if (f <= 3'd6) begin e.rw = 1'b1; e.rd = ins[7:5]; end
      end
      2'd1: begin
        e.r1 = rdreg(a); e.r2 = rdreg(a); e.alu = 3'd5;
        if (f == 3'd0 || f == 3'd2) begin e.mr = 1'b1; e.rw = 1'b1; e.rd = a; end
        if (f == 3'd1 || f == 3'd3) e.mw = 1'b1;
      end
      2'd2: begin
        e.r1 = rdreg(a); e.alu = 3'd5; e.jr = (f == 3'd1);
      end
      default: begin
        e.r1 = rdreg(a); e.r2 = rdreg(b); e.alu = 3'd6; e.bne = (f == 3'd0);
      end
    endcase
    return e;
  endfunction

  task automatic check_out();
    chk("ex_valid", bus.ex_valid, cur.valid);
    chk("regwrite", bus.regwrite_out, cur.valid & cur.rw);
    chk("memread", bus.memread_out, cur.valid & cur.mr);
    chk("pc_out", bus.pc_out, cur.pc);
    if (cur.valid) begin
      chk("reg1data", bus.reg1data_out, cur.r1);
      chk("alufunct", bus.ALUfunct_out, cur.alu);
      chk("op", bus.op_out, cur.op);
      chk("funct", bus.funct_out, cur.fn);
      chk("bne", bus.bne_out, cur.bne);
      chk("jr", bus.jr_out, cur.jr);
      chk("memwrite", bus.memwrite_out, cur.mw);
      if (cur.op != 2'd2) chk("reg2data", bus.reg2data_out, cur.r2);
      case (cur.op)
        2'd0:    chk("shamt", bus.shamt_out, cur.sh);
        2'd1:    chk("memaddr", bus.memaddr_out, cur.ma);
        2'd2:    chk("jtarget", bus.jtarget_out, cur.jt);
        default: chk("boffset", bus.boffset_out, cur.bo);
      endcase
      if (cur.rw) chk("rd_out", bus.rd_out, cur.rd);
    end
  endtask

  // Called at posedge+1; presents inputs, checks if_ready, clocks, checks ID/EX.
  task automatic step(input logic v, input logic [15:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [2:0] wa, input logic [15:0] wd);
    logic hz, rdy;
    exp_t nxt;
    bus.if_valid = v; bus.instr_in = ins; bus.pc_in = pc; bus.flush = fl;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
    hz = 1'b0;
`ifdef NQ_LOADUSE_STALL_EN
    hz = cur.valid && cur.mr && cur.rd != 3'd0 && v &&
         (ins[13:11] == cur.rd || ((ins[15:14] == 2'd0 || ins[15:14] == 2'd3) && ins[10:8] == cur.rd));
`endif
    rdy = !fl && !hz;
    chk("if_ready", bus.if_ready, rdy);
    nxt = cur;
    nxt.valid = 1'b0;
    if (v && rdy) nxt = model_decode(ins, pc);
    if (we && wa != 3'd0) mrf[wa] = wd;
    @(posedge clk);
    #1;
    cur = nxt;
    check_out();
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.instr_in = '0; bus.pc_in = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
    cur = '0;

    #2;
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_regwrite", bus.regwrite_out, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_if_ready", bus.if_ready, 1'b1);

    // Writeback then R-type ADD r1,r2 -> r3, shamt 01
    step(0, 16'h0, 32'h0, 0, 1, 3'd1, 16'h00F0);
    step(0, 16'h0, 32'h0, 0, 1, 3'd2, 16'h0F0F);
    step(1, 16'h0A6D, 32'h100, 0, 0, 3'd0, 16'h0);
    chk("add_valid", bus.ex_valid, 1'b1);
    chk("add_r1", bus.reg1data_out, 16'h00F0);
    chk("add_r2", bus.reg2data_out, 16'h0F0F);
    chk("add_alu", bus.ALUfunct_out, 3'b101);
    chk("add_shamt", bus.shamt_out, 2'b01);
    chk("add_rd", bus.rd_out, 3'd3);
    chk("add_rw", bus.regwrite_out, 1'b1);

    // Write-through on r4, and r0 stays zero
    step(1, 16'h2025, 32'h102, 0, 1, 3'd4, 16'hBEEF);
    chk("wt_r4", bus.reg1data_out, 16'hBEEF);
    step(1, 16'h0025, 32'h104, 0, 1, 3'd0, 16'hFFFF);
    chk("r0_r1", bus.reg1data_out, 16'h0);
    chk("r0_r2", bus.reg2data_out, 16'h0);

    // LW r5, JR r5, BNE r1,r2
    step(1, 16'h6AA0, 32'h106, 0, 0, 3'd0, 16'h0);
    chk("lw_memread", bus.memread_out, 1'b1);
    chk("lw_alu", bus.ALUfunct_out, 3'b101);
    chk("lw_rd", bus.rd_out, 3'd5);
    step(0, 16'h0, 32'h0, 0, 0, 3'd0, 16'h0);
    step(1, 16'hA801, 32'h108, 0, 0, 3'd0, 16'h0);
    chk("jr_flag", bus.jr_out, 1'b1);
    chk("jr_rw", bus.regwrite_out, 1'b0);
    step(1, 16'hCA70, 32'h10A, 0, 0, 3'd0, 16'h0);
    chk("bne_flag", bus.bne_out, 1'b1);
    chk("bne_alu", bus.ALUfunct_out, 3'b110);
    chk("bne_off", bus.boffset_out, 5'b01110);

    // Flush with a valid instruction
    step(1, 16'h0A6D, 32'h10C, 1, 0, 3'd0, 16'h0);
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_pc", bus.pc_out, 32'h10A);

    // Load-use: LW r3 then ADD reading r3
    step(1, 16'h5800, 32'h200, 0, 0, 3'd0, 16'h0);
    step(1, 16'h18C5, 32'h202, 0, 0, 3'd0, 16'h0);
`ifdef NQ_LOADUSE_STALL_EN
    chk("lu_bubble", bus.ex_valid, 1'b0);
    step(1, 16'h18C5, 32'h202, 0, 0, 3'd0, 16'h0);
`endif
    chk("lu_add_valid", bus.ex_valid, 1'b1);
    chk("lu_add_pc", bus.pc_out, 32'h202);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), $urandom, ($urandom % 8) == 0,
           1'($urandom), 3'($urandom), 16'($urandom));
    end

    // Asynchronous reset while a load-use pair is in flight
    step(1, 16'h5800, 32'h300, 0, 0, 3'd0, 16'h0);
    bus.if_valid = 1'b1; bus.instr_in = 16'h18C5; bus.pc_in = 32'h302;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_ex_valid", bus.ex_valid, 1'b0);
    chk("mr_memread", bus.memread_out, 1'b0);
    chk("mr_pc", bus.pc_out, 32'h0);
    chk("mr_r1", bus.reg1data_out, 16'h0);
    chk("mr_rd", bus.rd_out, 3'd0);
    chk("mr_if_ready", bus.if_ready, 1'b0);
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
    cur = '0;
    @(negedge clk);
    rst = 1'b1;
    bus.if_valid = 1'b0;
    @(posedge clk); #1;
    chk("mr_rel_ready", bus.if_ready, 1'b1);
    step(1, 16'h0A6D, 32'h400, 0, 0, 3'd0, 16'h0);
    chk("mr_rf_cleared", bus.reg1data_out, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
